// File: rtl/mem_access_arbiter_pkg.sv
// Shared definitions for the memory access arbiter: FSM encoding, requester indices
// and the timeout compare helper.
package mem_access_arbiter_pkg;

  typedef logic [1:0] state_t;

  localparam state_t StIdle   = 2'd0;
  localparam state_t StLoad   = 2'd1;
  localparam state_t StAccess = 2'd2;
  localparam state_t StDone   = 2'd3;

  localparam logic PortFetch = 1'b0;
  localparam logic PortExec  = 1'b1;

  localparam int unsigned CntWidth = 8;

  // True on the last ACCESS cycle allowed before the transaction is abandoned.
  function automatic logic timeout_hit(input logic [CntWidth-1:0] cnt,
                                       input int unsigned limit);
    return cnt == CntWidth'(limit - 1);
  endfunction

endpackage

// File: rtl/mem_access_arbiter_rr_arbiter2.sv
// Two-input round-robin grant: a lone request wins outright, and on a tie the port
// that did not win last time gets the grant.
module mem_access_arbiter_rr_arbiter2 (
  input  logic req0_i,
  input  logic req1_i,
  input  logic last_grant_i,
  output logic valid_o,
  output logic grant_o
);

  always_comb begin
    valid_o = req0_i | req1_i;
    if (req0_i && req1_i) begin
      grant_o = ~last_grant_i;
    end else begin
      grant_o = req1_i;
    end
  end

endmodule

// File: rtl/mem_access_arbiter.sv
// Arbitrates fetch and execute memory requests, sequencing MAR/MDR through a single
// read or write transaction with ready handshake and timeout.
module mem_access_arbiter
  import mem_access_arbiter_pkg::*;
#(
  parameter int unsigned BitsData = 32,
  parameter int unsigned BitsAddr = 16,
  parameter int unsigned Timeout  = 15
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                req0_i,
  input  logic                we0_i,
  input  logic [BitsAddr-1:0] addr0_i,
  input  logic [BitsData-1:0] wdata0_i,
  input  logic                req1_i,
  input  logic                we1_i,
  input  logic [BitsAddr-1:0] addr1_i,
  input  logic [BitsData-1:0] wdata1_i,
  output logic                ack0_o,
  output logic                ack1_o,
  output logic                err_o,
  output logic [BitsData-1:0] rdata_o,
  output logic                busy_o,
  output logic [BitsAddr-1:0] mem_addr_o,
  output logic [BitsData-1:0] mem_wdata_o,
  output logic                mem_read_o,
  output logic                mem_write_o,
  input  logic [BitsData-1:0] mem_rdata_i,
  input  logic                mem_ready_i
);

  state_t                state_q, state_d;
  logic                  winner_q, winner_d;
  logic                  we_q, we_d;
  logic [BitsAddr-1:0]   addr_q, addr_d;
  logic [BitsData-1:0]   wdata_q, wdata_d;
  logic [BitsAddr-1:0]   mar_q, mar_d;
  logic [BitsData-1:0]   mdr_q, mdr_d;
  logic [BitsData-1:0]   rdata_q, rdata_d;
  logic [CntWidth-1:0]   cnt_q, cnt_d;
  logic                  err_q, err_d;
  logic                  last_grant_q, last_grant_d;
  logic                  gnt_valid;
  logic                  gnt_idx;

  mem_access_arbiter_rr_arbiter2 u_rr_arbiter2 (
    .req0_i       (req0_i),
    .req1_i       (req1_i),
    .last_grant_i (last_grant_q),
    .valid_o      (gnt_valid),
    .grant_o      (gnt_idx)
  );

  always_comb begin
    state_d      = state_q;
    winner_d     = winner_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    mar_d        = mar_q;
    mdr_d        = mdr_q;
    rdata_d      = rdata_q;
    cnt_d        = cnt_q;
    err_d        = err_q;
    last_grant_d = last_grant_q;
    case (state_q)
      StIdle: begin
        if (gnt_valid) begin
          winner_d = gnt_idx;
          if (gnt_idx == PortExec) begin
            we_d    = we1_i;
            addr_d  = addr1_i;
            wdata_d = wdata1_i;
          end else begin
            we_d    = we0_i;
            addr_d  = addr0_i;
            wdata_d = wdata0_i;
          end
          state_d = StLoad;
        end
      end
      StLoad: begin
        mar_d = addr_q;
        if (we_q) begin
          mdr_d = wdata_q;
        end
        cnt_d   = '0;
        err_d   = 1'b0;
        state_d = StAccess;
      end
      StAccess: begin
        if (mem_ready_i) begin
          if (!we_q) begin
            mdr_d   = mem_rdata_i;
            rdata_d = mem_rdata_i;
          end
          err_d   = 1'b0;
          state_d = StDone;
        end else if (timeout_hit(cnt_q, Timeout)) begin
          err_d   = 1'b1;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDone: begin
        last_grant_d = winner_q;
        state_d      = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      winner_q     <= PortFetch;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      mar_q        <= '0;
      mdr_q        <= '0;
      rdata_q      <= '0;
      cnt_q        <= '0;
      err_q        <= 1'b0;
      // Port 0 wins the first tie after reset.
      last_grant_q <= PortExec;
    end else begin
      state_q      <= state_d;
      winner_q     <= winner_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      mar_q        <= mar_d;
      mdr_q        <= mdr_d;
      rdata_q      <= rdata_d;
      cnt_q        <= cnt_d;
      err_q        <= err_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Outputs decode straight from state so an async reset drops them at once.
  always_comb begin
    busy_o      = (state_q != StIdle);
    mem_read_o  = (state_q == StAccess) && !we_q;
    mem_write_o = (state_q == StAccess) && we_q;
    ack0_o      = (state_q == StDone) && (winner_q == PortFetch);
    ack1_o      = (state_q == StDone) && (winner_q == PortExec);
    err_o       = (state_q == StDone) && err_q;
    rdata_o     = rdata_q;
    mem_addr_o  = mar_q;
    mem_wdata_o = mdr_q;
  end

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Self-checking bench for mem_access_arbiter: directed vector table, hand-written
// corner sequences and randomized transactions against a transaction-level model.
module tb_mem_access_arbiter;

  localparam int Timeout = 15;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
  logic [15:0] addr0 = '0, addr1 = '0;
  logic [31:0] wdata0 = '0, wdata1 = '0;
  logic        ack0, ack1, err, busy, mem_read, mem_write;
  logic [31:0] rdata, mem_wdata;
  logic [15:0] mem_addr;
  logic [31:0] mem_rdata = '0;
  logic        mem_ready = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mem_access_arbiter #(
    .BitsData (32),
    .BitsAddr (16),
    .Timeout  (Timeout)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req0_i      (req0),
    .we0_i       (we0),
    .addr0_i     (addr0),
    .wdata0_i    (wdata0),
    .req1_i      (req1),
    .we1_i       (we1),
    .addr1_i     (addr1),
    .wdata1_i    (wdata1),
    .ack0_o      (ack0),
    .ack1_o      (ack1),
    .err_o       (err),
    .rdata_o     (rdata),
    .busy_o      (busy),
    .mem_addr_o  (mem_addr),
    .mem_wdata_o (mem_wdata),
    .mem_read_o  (mem_read),
    .mem_write_o (mem_write),
    .mem_rdata_i (mem_rdata),
    .mem_ready_i (mem_ready)
  );

  typedef struct {
    logic        r0, r1, w0, w1;
    logic [15:0] a0, a1;
    logic [31:0] d0, d1;
    int          waits;
    logic [31:0] mrd;
    logic        exp_win;
    logic        exp_err;
    logic [31:0] exp_rdata;
    logic [31:0] exp_mdata;
    int          exp_lat;
    int          exp_stb;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req0 = 0; req1 = 0; we0 = 0; we1 = 0; mem_ready = 0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
  task automatic do_txn(input logic r0, r1, w0, w1, input logic [15:0] a0, a1,
                        input logic [31:0] d0, d1, input int waits, input logic [31:0] mrd,
                        input logic [15:0] exp_addr, input logic [31:0] exp_mdata,
                        input logic exp_we,
                        output logic win, output logic got_err, output logic [31:0] got_rdata,
                        output int lat, output int stb, output logic bus_ok);
    int  cyc;
    bit  done;
    req0 = r0; req1 = r1; we0 = w0; we1 = w1;
    addr0 = a0; addr1 = a1; wdata0 = d0; wdata1 = d1;
    mem_rdata = mrd; mem_ready = 1'b0;
    stb = 0; lat = -1; win = 1'bx; got_err = 1'bx; got_rdata = 'x; bus_ok = 1'b1;
    cyc = 0; done = 0;
    while (!done && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (ack0 && ack1) bus_ok = 1'b0;
      if (ack0 || ack1) begin
        win = ack1; got_err = err; got_rdata = rdata; lat = cyc;
        done = 1;
      end else if (mem_read || mem_write) begin
        stb++;
        if (mem_addr !== exp_addr || mem_wdata !== exp_mdata ||
            mem_write !== exp_we || mem_read !== !exp_we) bus_ok = 1'b0;
        mem_ready = (stb > waits);
      end else begin
        mem_ready = 1'($urandom_range(0, 1));
      end
    end
    req0 = 0; req1 = 0; mem_ready = 1'b0;
    if (!done) begin
      n_tests++; n_fail++;
      $display("FAIL txn_timeout: no ack within 40 cycles, expected one");
    end
    @(negedge clk);
  endtask

  task automatic run_checked(input string tag, input vec_t v);
    logic        win, gerr, ok;
    logic [31:0] grd;
    int          lat, stb;
    do_txn(v.r0, v.r1, v.w0, v.w1, v.a0, v.a1, v.d0, v.d1, v.waits, v.mrd,
           v.exp_win ? v.a1 : v.a0, v.exp_mdata, v.exp_win ? v.w1 : v.w0,
           win, gerr, grd, lat, stb, ok);
    check({tag, " winner"}, 64'(win), 64'(v.exp_win));
    check({tag, " err"}, 64'(gerr), 64'(v.exp_err));
    check({tag, " rdata"}, 64'(grd), 64'(v.exp_rdata));
    check({tag, " ack latency"}, 64'(lat), 64'(v.exp_lat));
    check({tag, " strobe cycles"}, 64'(stb), 64'(v.exp_stb));
    check({tag, " bus values"}, 64'(ok), 64'(1));
  endtask

  vec_t vecs[7];

  initial begin
    vecs[0] = '{1, 0, 0, 0, 16'h0010, 16'h0000, 32'h0, 32'h0, 0, 32'hDEADBEEF,
                0, 0, 32'hDEADBEEF, 32'h0, 3, 1};
    vecs[1] = '{0, 1, 0, 1, 16'h0000, 16'h00FF, 32'h0, 32'h12345678, 3, 32'h0,
                1, 0, 32'hDEADBEEF, 32'h12345678, 6, 4};
    vecs[2] = '{1, 1, 0, 0, 16'h0100, 16'h0200, 32'h0, 32'h0, 1, 32'hCAFEF00D,
                0, 0, 32'hCAFEF00D, 32'h12345678, 4, 2};
    vecs[3] = '{1, 1, 1, 1, 16'h0300, 16'h0400, 32'h11111111, 32'h22222222, 0, 32'h0,
                1, 0, 32'hCAFEF00D, 32'h22222222, 3, 1};
    vecs[4] = '{1, 0, 0, 0, 16'h0500, 16'h0000, 32'h0, 32'h0, 20, 32'h55555555,
                0, 1, 32'hCAFEF00D, 32'h22222222, 17, 15};
    vecs[5] = '{0, 1, 0, 0, 16'h0000, 16'h0600, 32'h0, 32'h0, 2, 32'hA5A5A5A5,
                1, 0, 32'hA5A5A5A5, 32'h22222222, 5, 3};
    vecs[6] = '{1, 1, 1, 0, 16'h0700, 16'h0800, 32'h33333333, 32'h0, 0, 32'h0,
                0, 0, 32'hA5A5A5A5, 32'h33333333, 3, 1};

    // Reset state, sampled while reset is held.
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("reset outputs", {ack0, ack1, err, busy, mem_read, mem_write}, 6'b0);
    check("reset rdata/mar/mdr", {rdata, mem_addr, mem_wdata}, 80'h0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) run_checked($sformatf("vec%0d", i), vecs[i]);

    // memReady while idle must be ignored.
    begin
      logic seen;
      seen = 1'b0;
      mem_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        if (busy || ack0 || ack1 || mem_read || mem_write) seen = 1'b1;
      end
      mem_ready = 1'b0;
      check("idle ready ignored", 64'(seen), 64'(0));
    end

    // Both ports held, zero-wait memory: grants alternate 0,1,0,1 every 4 cycles.
    do_reset();
    begin
      logic [3:0] order;
      int         t[4];
      int         n_ack;
      logic       both;
      order = '0; n_ack = 0; both = 1'b0;
      req0 = 1; req1 = 1; we0 = 0; we1 = 0; addr0 = 16'h1000; addr1 = 16'h2000;
      mem_rdata = 32'h0BAD_F00D; mem_ready = 1'b1;
      for (int c = 1; c <= 30 && n_ack < 4; c++) begin
        @(negedge clk);
        if (ack0 && ack1) both = 1'b1;
        if (ack0 || ack1) begin
          order[n_ack] = ack1;
          t[n_ack] = c;
          n_ack++;
        end
      end
      req0 = 0; req1 = 0; mem_ready = 1'b0;
      @(negedge clk);
      check("alt ack count", 64'(n_ack), 64'(4));
      check("alt grant order", 64'(order), 64'(4'b1010));
      check("alt acks overlap", 64'(both), 64'(0));
      if (n_ack == 4) begin
        check("alt first ack", 64'(t[0]), 64'(3));
        check("alt turnaround", 64'(t[3] - t[0]), 64'(12));
      end
    end

    // Reset during ACCESS: strobes and busy drop immediately, no ack, req1 served after.
    do_reset();
    begin
      logic        seen_strobe, seen_ack;
      vec_t        v;
      seen_strobe = 1'b0; seen_ack = 1'b0;
      req0 = 1; req1 = 1; we0 = 0; we1 = 1; addr0 = 16'h0ABC; addr1 = 16'h0DEF;
      wdata1 = 32'h7777_1234;
      for (int c = 0; c < 10 && !seen_strobe; c++) begin
        @(negedge clk);
        if (mem_read) seen_strobe = 1'b1;
      end
      check("mid reset strobe seen", 64'(seen_strobe), 64'(1));
      check("mid reset addr", 64'(mem_addr), 64'(16'h0ABC));
      #1 rst = 1'b1;
      #1;
      check("mid reset drop", {busy, mem_read, mem_write, ack0, ack1}, 5'b0);
      req0 = 0;
      @(negedge clk);
      if (ack0 || ack1) seen_ack = 1'b1;
      check("mid reset no ack", 64'(seen_ack), 64'(0));
      check("mid reset rdata", 64'(rdata), 64'(0));
      rst = 1'b0;
      v = '{0, 1, 0, 1, 16'h0000, 16'h0DEF, 32'h0, 32'h7777_1234, 1, 32'h0,
            1, 0, 32'h0, 32'h7777_1234, 4, 2};
      run_checked("after reset", v);
    end

    // Randomized transactions against a transaction-level model.
    do_reset();
    begin
      logic        m_last, r0, r1, w0, w1, win;
      logic [31:0] m_mdr, m_rdata, d0, d1, mrd, exp_md;
      logic [15:0] a0, a1;
      int          waits;
      bit          to;
      vec_t        v;
      m_last = 1'b1; m_mdr = '0; m_rdata = '0;
      for (int i = 0; i < 40; i++) begin
        r0 = 1'($urandom_range(0, 1));
        r1 = r0 ? 1'($urandom_range(0, 1)) : 1'b1;
        w0 = 1'($urandom_range(0, 1)); w1 = 1'($urandom_range(0, 1));
        a0 = 16'($urandom); a1 = 16'($urandom);
        d0 = $urandom; d1 = $urandom; mrd = $urandom;
        waits = $urandom_range(0, 17);
        win = (r0 && r1) ? !m_last : r1;
        to = (waits >= Timeout);
        exp_md = (win ? w1 : w0) ? (win ? d1 : d0) : m_mdr;
        if (win ? w1 : w0) m_mdr = exp_md;
        else if (!to) begin m_mdr = mrd; m_rdata = mrd; end
        m_last = win;
        v = '{r0, r1, w0, w1, a0, a1, d0, d1, waits, mrd, win, to, m_rdata, exp_md,
              3 + (to ? Timeout - 1 : waits), to ? Timeout : waits + 1};
        run_checked($sformatf("rand%0d", i), v);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
